// File: rtl/output_buffer_gen2_pkg.sv
// Pipeline-wide defaults for the output buffer.
// Keep 2**DEF_DEPTH_LOG2 - DEF_SLOW_ON above the worst-case pipeline drain depth.
package output_buffer_gen2_pkg;

    localparam int DEF_WIDTH      = 64;
    localparam int DEF_DEPTH_LOG2 = 13;
    localparam int DEF_SLOW_ON    = 1000;
    localparam int DEF_SLOW_OFF   = 500;

endpackage : output_buffer_gen2_pkg

// File: rtl/output_buffer_gen2_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-held read data output.
module output_buffer_gen2_sdp_ram
    import output_buffer_gen2_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : output_buffer_gen2_sdp_ram

// File: rtl/output_buffer_gen2.sv
// Show-ahead FIFO between the counting pipeline and the host consumer, with
// hysteresis backpressure, sticky overflow and a fill high-watermark.
module output_buffer_gen2
    import output_buffer_gen2_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int SLOW_ON    = DEF_SLOW_ON,
    parameter int SLOW_OFF   = DEF_SLOW_OFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dataInValid,
    input  logic [WIDTH-1:0]      dataIn,
    output logic                  slowInputting,
    output logic                  overflow,
    input  logic                  clearStats,
    input  logic                  dataOutReady,
    output logic                  dataOutValid,
    output logic [WIDTH-1:0]      dataOut,
    output logic [DEPTH_LOG2:0]   fullness,
    output logic [DEPTH_LOG2:0]   maxFullness
);

    localparam int                  RAM_WORDS  = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] RAM_FULL_C = (DEPTH_LOG2+1)'(RAM_WORDS);
    localparam logic [DEPTH_LOG2:0] SLOW_ON_C  = (DEPTH_LOG2+1)'(SLOW_ON);
    localparam logic [DEPTH_LOG2:0] SLOW_OFF_C = (DEPTH_LOG2+1)'(SLOW_OFF);

    generate
        if (SLOW_OFF >= SLOW_ON) begin : g_bad_hysteresis
            $error("output_buffer_gen2: SLOW_OFF must be below SLOW_ON");
        end
    endgenerate

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   ram_count_q, ram_count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DEPTH_LOG2:0]   fullness_q, fullness_d;
    logic [DEPTH_LOG2:0]   max_fullness_q, max_fullness_d;
    logic                  overflow_q, overflow_d;
    logic                  slow_q, slow_d;

    logic wr_en;
    logic drop;
    logic pop;
    logic rd_en;

    // The RAM read register is the output stage, so a read is issued whenever
    // that stage is empty or being popped and the RAM has a word to give.
    always_comb begin
        wr_en = dataInValid && (ram_count_q != RAM_FULL_C);
        drop  = dataInValid && (ram_count_q == RAM_FULL_C);
        pop   = out_valid_q && dataOutReady;
        rd_en = (ram_count_q != '0) && (!out_valid_q || pop);

        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

        ram_count_d = ram_count_q;
        case ({wr_en, rd_en})
            2'b10:   ram_count_d = ram_count_q + 1'b1;
            2'b01:   ram_count_d = ram_count_q - 1'b1;
            default: ram_count_d = ram_count_q;
        endcase

        if (rd_en) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        fullness_d = fullness_q;
        case ({wr_en, pop})
            2'b10:   fullness_d = fullness_q + 1'b1;
            2'b01:   fullness_d = fullness_q - 1'b1;
            default: fullness_d = fullness_q;
        endcase
    end

    // Statistics and backpressure all look at the registered fullness.
    always_comb begin
        if (clearStats) begin
            max_fullness_d = fullness_q;
        end else if (fullness_q > max_fullness_q) begin
            max_fullness_d = fullness_q;
        end else begin
            max_fullness_d = max_fullness_q;
        end

        overflow_d = drop || (overflow_q && !clearStats);

        if (fullness_q >= SLOW_ON_C) begin
            slow_d = 1'b1;
        end else if (fullness_q <= SLOW_OFF_C) begin
            slow_d = 1'b0;
        end else begin
            slow_d = slow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ram_count_q    <= '0;
            out_valid_q    <= 1'b0;
            fullness_q     <= '0;
            max_fullness_q <= '0;
            overflow_q     <= 1'b0;
            slow_q         <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ram_count_q    <= ram_count_d;
            out_valid_q    <= out_valid_d;
            fullness_q     <= fullness_d;
            max_fullness_q <= max_fullness_d;
            overflow_q     <= overflow_d;
            slow_q         <= slow_d;
        end
    end

    output_buffer_gen2_sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_sdp_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (dataIn),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (dataOut)
    );

    assign dataOutValid  = out_valid_q;
    assign fullness      = fullness_q;
    assign maxFullness   = max_fullness_q;
    assign overflow      = overflow_q;
    assign slowInputting = slow_q;

endmodule : output_buffer_gen2

// File: tb/tb_output_buffer_gen2.sv
// Scoreboard bench for output_buffer_gen2: one default-sized instance (A) and
// one small instance (B, 16 RAM words, SLOW_ON=10, SLOW_OFF=4).
module tb_output_buffer_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic        rstA, dataInValidA, clearStatsA, dataOutReadyA;
    logic [63:0] dataInA, dataOutA;
    logic        slowInputtingA, overflowA, dataOutValidA;
    logic [13:0] fullnessA, maxFullnessA;

    // Instance B: small buffer for hysteresis, overflow and wrap tests.
    logic        rstB, dataInValidB, clearStatsB, dataOutReadyB;
    logic [15:0] dataInB, dataOutB;
    logic        slowInputtingB, overflowB, dataOutValidB;
    logic [4:0]  fullnessB, maxFullnessB;

    output_buffer_gen2 #(
        .WIDTH(64), .DEPTH_LOG2(13), .SLOW_ON(1000), .SLOW_OFF(500)
    ) dutA (
        .clk(clk), .rst(rstA),
        .dataInValid(dataInValidA), .dataIn(dataInA),
        .slowInputting(slowInputtingA), .overflow(overflowA),
        .clearStats(clearStatsA), .dataOutReady(dataOutReadyA),
        .dataOutValid(dataOutValidA), .dataOut(dataOutA),
        .fullness(fullnessA), .maxFullness(maxFullnessA)
    );

    output_buffer_gen2 #(
        .WIDTH(16), .DEPTH_LOG2(4), .SLOW_ON(10), .SLOW_OFF(4)
    ) dutB (
        .clk(clk), .rst(rstB),
        .dataInValid(dataInValidB), .dataIn(dataInB),
        .slowInputting(slowInputtingB), .overflow(overflowB),
        .clearStats(clearStatsB), .dataOutReady(dataOutReadyB),
        .dataOutValid(dataOutValidB), .dataOut(dataOutB),
        .fullness(fullnessB), .maxFullness(maxFullnessB)
    );

    int          totalChecks  = 0;
    int          passedChecks = 0;
    logic [63:0] queueA[$];
    logic [63:0] queueB[$];
    logic [63:0] expA, expB;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one write for one cycle; kept words are expected on the output.
    task automatic applyStimulus(input bit onB, input logic [63:0] word, input bit kept);
        if (!onB) begin
            dataInValidA = 1'b1;
            dataInA      = word;
            if (kept) queueA.push_back(word);
        end else begin
            dataInValidB = 1'b1;
            dataInB      = word[15:0];
            if (kept) queueB.push_back(word);
        end
        tick();
    endtask

    task automatic drain(input bit onB, input string name);
        int cycles = 0;
        if (!onB) dataOutReadyA = 1'b1;
        else      dataOutReadyB = 1'b1;
        while ((onB ? queueB.size() : queueA.size()) != 0 && cycles < 200) begin
            tick();
            cycles++;
        end
        if (cycles >= 200) begin
            totalChecks++;
            $display("[TB] FAIL %s_timeout: %0d words still expected after %0d cycles",
                     name, onB ? queueB.size() : queueA.size(), cycles);
        end
        tick();
        if (!onB) begin
            checkOutput({name, "_valid_after_drain"}, 64'(dataOutValidA), 64'd0);
            checkOutput({name, "_fullness_after_drain"}, 64'(fullnessA), 64'd0);
        end else begin
            checkOutput({name, "_valid_after_drain"}, 64'(dataOutValidB), 64'd0);
            checkOutput({name, "_fullness_after_drain"}, 64'(fullnessB), 64'd0);
        end
    endtask

    // Monitors: every accepted head word must be the oldest expected word.
    always @(negedge clk) begin
        if (dataOutValidA && dataOutReadyA) begin
            if (queueA.size() == 0) begin
                totalChecks++;
                $display("[TB] FAIL a_unexpected_word: got 0x%0h, expected no word", dataOutA);
            end else begin
                expA = queueA.pop_front();
                checkOutput("a_data", dataOutA, expA);
            end
        end
    end

    always @(negedge clk) begin
        if (dataOutValidB && dataOutReadyB) begin
            if (queueB.size() == 0) begin
                totalChecks++;
                $display("[TB] FAIL b_unexpected_word: got 0x%0h, expected no word", dataOutB);
            end else begin
                expB = queueB.pop_front();
                checkOutput("b_data", 64'(dataOutB), expB);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA = 1'b1; dataInValidA = 1'b0; clearStatsA = 1'b0; dataOutReadyA = 1'b0; dataInA = '0;
        rstB = 1'b1; dataInValidB = 1'b0; clearStatsB = 1'b0; dataOutReadyB = 1'b0; dataInB = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_a_valid",    64'(dataOutValidA),  64'd0);
        checkOutput("rst_a_fullness", 64'(fullnessA),      64'd0);
        checkOutput("rst_a_max",      64'(maxFullnessA),   64'd0);
        checkOutput("rst_a_overflow", 64'(overflowA),      64'd0);
        checkOutput("rst_a_slow",     64'(slowInputtingA), 64'd0);
        checkOutput("rst_b_valid",    64'(dataOutValidB),  64'd0);
        checkOutput("rst_b_fullness", 64'(fullnessB),      64'd0);
        checkOutput("rst_b_overflow", 64'(overflowB),      64'd0);
        checkOutput("rst_b_slow",     64'(slowInputtingB), 64'd0);
        rstA = 1'b0;
        rstB = 1'b0;
        tick();

        // Three back-to-back words, consumer always ready.
        dataOutReadyA = 1'b1;
        applyStimulus(1'b0, 64'h1, 1'b1);
        checkOutput("t1_valid_cycle1", 64'(dataOutValidA), 64'd0);
        applyStimulus(1'b0, 64'h2, 1'b1);
        checkOutput("t1_valid_cycle2", 64'(dataOutValidA), 64'd1);
        checkOutput("t1_head_cycle2",  dataOutA, 64'h1);
        applyStimulus(1'b0, 64'h3, 1'b1);
        dataInValidA = 1'b0;
        repeat (3) tick();
        checkOutput("t1_fullness_end", 64'(fullnessA), 64'd0);
        checkOutput("t1_queue_empty",  64'(queueA.size()), 64'd0);

        // Twenty words with a stalled consumer, then full-rate drain.
        dataOutReadyA = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 64'h100 + 64'(i), 1'b1);
        dataInValidA = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t2_stall_hold", dataOutA, 64'h100);
        end
        checkOutput("t2_stall_valid", 64'(dataOutValidA), 64'd1);
        @(posedge clk);
        #1;
        dataOutReadyA = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("t2_no_bubble", 64'(dataOutValidA), 64'd1);
        end
        @(posedge clk);
        #1;
        checkOutput("t2_valid_end",    64'(dataOutValidA), 64'd0);
        checkOutput("t2_fullness_end", 64'(fullnessA), 64'd0);
        checkOutput("t2_max",          64'(maxFullnessA), 64'd20);
        checkOutput("t2_queue_empty",  64'(queueA.size()), 64'd0);

        // Reset with seven words stored, then a fresh word.
        dataOutReadyA = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 64'h200 + 64'(i), 1'b1);
        dataInValidA = 1'b0;
        tick();
        checkOutput("t6_fullness_before", 64'(fullnessA), 64'd7);
        #2;
        rstA = 1'b1;
        #1;
        checkOutput("t6_rst_valid",    64'(dataOutValidA), 64'd0);
        checkOutput("t6_rst_fullness", 64'(fullnessA), 64'd0);
        checkOutput("t6_rst_max",      64'(maxFullnessA), 64'd0);
        queueA.delete();
        tick();
        rstA = 1'b0;
        dataOutReadyA = 1'b1;
        tick();
        applyStimulus(1'b0, 64'hAA, 1'b1);
        dataInValidA = 1'b0;
        checkOutput("t6_valid_cycle1", 64'(dataOutValidA), 64'd0);
        tick();
        checkOutput("t6_valid_cycle2", 64'(dataOutValidA), 64'd1);
        checkOutput("t6_head_cycle2",  dataOutA, 64'hAA);
        drain(1'b0, "t6");

        // Hysteresis on instance B.
        dataOutReadyB = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 64'h10 + 64'(i), 1'b1);
        dataInValidB = 1'b0;
        checkOutput("t3_fullness_10", 64'(fullnessB), 64'd10);
        checkOutput("t3_slow_before", 64'(slowInputtingB), 64'd0);
        tick();
        checkOutput("t3_slow_set", 64'(slowInputtingB), 64'd1);
        dataOutReadyB = 1'b1;
        repeat (5) tick();
        dataOutReadyB = 1'b0;
        checkOutput("t3_fullness_5", 64'(fullnessB), 64'd5);
        tick();
        checkOutput("t3_slow_hold_5", 64'(slowInputtingB), 64'd1);
        dataOutReadyB = 1'b1;
        tick();
        dataOutReadyB = 1'b0;
        checkOutput("t3_fullness_4",  64'(fullnessB), 64'd4);
        checkOutput("t3_slow_hold_4", 64'(slowInputtingB), 64'd1);
        tick();
        checkOutput("t3_slow_clear", 64'(slowInputtingB), 64'd0);
        drain(1'b1, "t3");

        // Overflow: 16 RAM words plus the output stage, then a dropped word.
        dataOutReadyB = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 64'h40 + 64'(i), 1'b1);
        checkOutput("t4_overflow_at_full", 64'(overflowB), 64'd0);
        checkOutput("t4_fullness_17",      64'(fullnessB), 64'd17);
        applyStimulus(1'b1, 64'h99, 1'b0);
        dataInValidB = 1'b0;
        checkOutput("t4_overflow_set", 64'(overflowB), 64'd1);
        checkOutput("t4_fullness_drop", 64'(fullnessB), 64'd17);
        checkOutput("t4_max_17", 64'(maxFullnessB), 64'd17);
        dataOutReadyB = 1'b1;
        repeat (3) tick();
        dataOutReadyB = 1'b0;
        checkOutput("t4_fullness_14", 64'(fullnessB), 64'd14);
        clearStatsB = 1'b1;
        tick();
        clearStatsB = 1'b0;
        checkOutput("t4_clear_overflow", 64'(overflowB), 64'd0);
        checkOutput("t4_clear_max",      64'(maxFullnessB), 64'd14);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h51 + 64'(i), 1'b1);
        checkOutput("t4_refill_17", 64'(fullnessB), 64'd17);
        clearStatsB = 1'b1;
        applyStimulus(1'b1, 64'h9A, 1'b0);
        clearStatsB = 1'b0;
        dataInValidB = 1'b0;
        checkOutput("t4_set_wins", 64'(overflowB), 64'd1);
        checkOutput("t4_clear_max_full", 64'(maxFullnessB), 64'd17);
        drain(1'b1, "t4");

        // Continuous write and pop across several pointer wraps.
        clearStatsB = 1'b1;
        tick();
        clearStatsB = 1'b0;
        checkOutput("t5_max_cleared", 64'(maxFullnessB), 64'd0);
        dataOutReadyB = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 64'h1000 + 64'(i), 1'b1);
            if (i == 20 || i == 60 || i == 99) begin
                checkOutput("t5_fullness_steady", 64'(fullnessB), 64'd2);
            end
        end
        dataInValidB = 1'b0;
        checkOutput("t5_max_steady", 64'(maxFullnessB), 64'd2);
        drain(1'b1, "t5");

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule : tb_output_buffer_gen2
